arbitro_de_funcionalidade: RTL and testbench
============================================

ARBITRO_DE_FUNCIONALIDADE -- requirements
Module: arbitro_de_funcionalidade

Interface
REQ-001 Parameters, SHALL be: N_USERS, default 4, number of requesting channels (2..8); HOLD_CYCLES, default 8, maximum cycles a grant is held (2..255).
REQ-002 Clock  input  1  single clock; all state updates on the rising edge.
REQ-003 Reset  input  1  synchronous, active-high; one clock, reset is synchronous and active-high.
REQ-004 Req  input  N_USERS  per-channel request, active-high, level-sensitive.
REQ-005 User  input  3*N_USERS  per-channel user level, channel i in bits [3i+2:3i]; 0 = no user, 7 = highest.
REQ-006 Func  input  3*N_USERS  per-channel function code, channel i in bits [3i+2:3i]; 0 = neutral.
REQ-007 Grant  output  N_USERS  one-hot active grant; all-zero when none.
REQ-008 GrantFunc  output  3  function code latched at grant; 0 when no grant.
REQ-009 Matriz  output  7  LED matrix row drive; bit (GrantFunc-1) high while granted, else 0.
REQ-010 Denied  output  N_USERS  registered per-channel permission-failure flag.
REQ-011 Busy  output  1  high in ACTIVE and GAP.
REQ-012 Timeout  output  1  one-cycle pulse when a grant is removed by the hold limit.

Function
REQ-013 Eligibility: channel i is eligible when Req[i]=1, Func_i!=0, User_i!=0, permission holds, and channel i is not locked out.
REQ-014 Permission: Func 1-3 need level >=1; Func 4-5 need level >=3; Func 6-7 need level >=5.
REQ-015 Denied[i] SHALL be 1 in the cycle after any cycle with Req[i]=1, Func_i!=0 and permission failing (incl. User_i=0), in every state; else 0.
REQ-016 States SHALL be IDLE, ACTIVE, GAP.
REQ-017 IDLE: if any channel eligible, next edge -> ACTIVE with Grant, GrantFunc, Matriz registered together (1-cycle latency Req->Grant); else stay.
REQ-018 Arbitration: highest User level wins; ties broken round-robin, searching from (last granted index + 1) mod N_USERS upward.
REQ-019 Round-robin pointer SHALL update only on a grant; after reset search starts at index 0.
REQ-020 ACTIVE: hold counter starts at 0 on the grant edge, increments each cycle; GrantFunc and grantee frozen; Func/User changes on grantee ignored.
REQ-021 ACTIVE exit: Req[grantee]=0 -> next edge GAP, no Timeout; counter = HOLD_CYCLES-1 with Req still high -> next edge GAP, Timeout=1 for that one cycle, grantee locked out. Grant lasts exactly HOLD_CYCLES cycles max.
REQ-022 If both exit conditions coincide, the Req-drop release SHALL take precedence (no Timeout, no lockout).
REQ-023 GAP: Grant=0, GrantFunc=0, Matriz=0, Busy=1 for exactly one cycle, then IDLE; requests are not granted in GAP.
REQ-024 Lockout for channel i SHALL clear on the first edge at which Req[i]=0; a locked channel is never eligible.
REQ-025 No preemption: a higher-level request arriving during ACTIVE waits for GAP->IDLE.
REQ-026 N_USERS=1 SHALL be illegal (elaboration error); counter width SHALL be ceil(log2(HOLD_CYCLES)).

Reset
REQ-027 On Reset=1 at an edge: state IDLE, Grant=0, GrantFunc=0, Matriz=0, Denied=0, Busy=0, Timeout=0, counter=0, RR pointer=0, all lockouts cleared.
REQ-028 Reset SHALL override every other condition including mid-ACTIVE; outputs are zero from the edge where Reset is sampled.

Verification (N_USERS=4, HOLD_CYCLES=8)
REQ-029 Reset held 2 cycles with random Req -> all outputs 0; first request after release granted one edge later.
REQ-030 Ch0 User=5 Func=1, Ch1 User=1 Func=1 same cycle -> Grant=0001, GrantFunc=1, Matriz=0000001, Busy=1; drop Req0 -> GAP one cycle, then Grant=0010.
REQ-031 Ch0 and Ch1 both User=3 Func=2, Req held low-high around each release -> grants alternate 0001, 0010, 0001.
REQ-032 Ch2 User=1 Func=6 only -> Denied=0100 next cycle, Grant stays 0000, state IDLE.
REQ-033 Ch3 User=7 Func=4 held 20 cycles, Ch1 User=2 Func=1 held -> Grant=1000 for 8 cycles, Timeout pulse 1 cycle, GAP, then Grant=0010; Ch3 regains eligibility only after Req3 low for one edge.
REQ-034 Reset asserted at ACTIVE cycle 3 -> Grant=0000, Busy=0 from that edge; Timeout never pulses.

Source files
------------

// File: rtl/arbitro_de_funcionalidade.sv
// Function-permission arbiter: grants one requesting channel at a time by user level,
// round-robin among equal levels, with a hold limit, per-channel lockout and a one-cycle gap.
module arbitro_de_funcionalidade #(
  parameter int N_USERS     = 4,
  parameter int HOLD_CYCLES = 8
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic [N_USERS-1:0]     Req,
  input  logic [3*N_USERS-1:0]   User,
  input  logic [3*N_USERS-1:0]   Func,
  output logic [N_USERS-1:0]     Grant,
  output logic [2:0]             GrantFunc,
  output logic [6:0]             Matriz,
  output logic [N_USERS-1:0]     Denied,
  output logic                   Busy,
  output logic                   Timeout
);

  localparam int CW = $clog2(HOLD_CYCLES);
  localparam int IW = $clog2(N_USERS);

  if (N_USERS < 2 || N_USERS > 8) begin : g_bad_users
    $error("arbitro_de_funcionalidade: N_USERS must be within 2..8");
  end
  if (HOLD_CYCLES < 2 || HOLD_CYCLES > 255) begin : g_bad_hold
    $error("arbitro_de_funcionalidade: HOLD_CYCLES must be within 2..255");
  end

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACTIVE = 2'd1, S_GAP = 2'd2} state_t;

  state_t               state_r, state_s;
  logic [CW-1:0]        cnt_r, cnt_s;
  logic [IW-1:0]        idx_r, idx_s;
  logic [IW-1:0]        rr_start_r, rr_start_s;
  logic [N_USERS-1:0]   lock_r, lock_s;
  logic [N_USERS-1:0]   elig_s, deny_s;
  logic [N_USERS-1:0]   grant_s;
  logic [2:0]           gfunc_s;
  logic                 timeout_s;
  logic [2:0]           best_lvl_s;
  logic                 win_any_s;
  logic [IW-1:0]        win_idx_s;
  logic [IW-1:0]        win_next_s;

  function automatic logic perm_ok(input logic [2:0] func, input logic [2:0] lvl);
    case (func)
      3'd1, 3'd2, 3'd3: perm_ok = (lvl >= 3'd1);
      3'd4, 3'd5:       perm_ok = (lvl >= 3'd3);
      3'd6, 3'd7:       perm_ok = (lvl >= 3'd5);
      default:          perm_ok = 1'b0;
    endcase
  endfunction

  // Per-channel eligibility and permission-failure detection
  always_comb begin
    elig_s = '0;
    deny_s = '0;
    for (int i = 0; i < N_USERS; i++) begin
      deny_s[i] = Req[i] && (Func[3*i +: 3] != 3'd0) && !perm_ok(Func[3*i +: 3], User[3*i +: 3]);
      elig_s[i] = Req[i] && (Func[3*i +: 3] != 3'd0) && (User[3*i +: 3] != 3'd0)
                  && perm_ok(Func[3*i +: 3], User[3*i +: 3]) && !lock_r[i];
    end
  end

  // Winner selection: highest level, ties resolved by scanning from the round-robin start
  always_comb begin
    int idx;
    idx        = 0;
    best_lvl_s = 3'd0;
    win_any_s  = 1'b0;
    win_idx_s  = '0;
    for (int i = 0; i < N_USERS; i++) begin
      if (elig_s[i] && (User[3*i +: 3] > best_lvl_s)) begin
        best_lvl_s = User[3*i +: 3];
      end else begin
        best_lvl_s = best_lvl_s;
      end
    end
    for (int k = 0; k < N_USERS; k++) begin
      idx = int'(rr_start_r) + k;
      if (idx >= N_USERS) begin
        idx = idx - N_USERS;
      end else begin
        idx = idx;
      end
      if (!win_any_s && elig_s[idx] && (User[3*idx +: 3] == best_lvl_s)) begin
        win_any_s = 1'b1;
        win_idx_s = IW'(idx);
      end else begin
        win_any_s = win_any_s;
      end
    end
    if (win_idx_s == IW'(N_USERS - 1)) begin
      win_next_s = '0;
    end else begin
      win_next_s = win_idx_s + {{(IW-1){1'b0}}, 1'b1};
    end
  end

  // Next-state, hold counter, lockout and grant outputs
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    idx_s      = idx_r;
    rr_start_s = rr_start_r;
    grant_s    = Grant;
    gfunc_s    = GrantFunc;
    timeout_s  = 1'b0;
    lock_s     = lock_r & Req;
    case (state_r)
      S_IDLE: begin
        if (win_any_s) begin
          state_s    = S_ACTIVE;
          cnt_s      = '0;
          idx_s      = win_idx_s;
          rr_start_s = win_next_s;
          grant_s    = {{(N_USERS-1){1'b0}}, 1'b1} << win_idx_s;
          gfunc_s    = Func[3*win_idx_s +: 3];
        end else begin
          grant_s = '0;
          gfunc_s = 3'd0;
        end
      end
      S_ACTIVE: begin
        // A request drop wins over the hold limit: no timeout, no lockout
        if (!Req[idx_r]) begin
          state_s = S_GAP;
          grant_s = '0;
          gfunc_s = 3'd0;
        end else if (cnt_r == CW'(HOLD_CYCLES - 1)) begin
          state_s        = S_GAP;
          grant_s        = '0;
          gfunc_s        = 3'd0;
          timeout_s      = 1'b1;
          lock_s[idx_r]  = 1'b1;
        end else begin
          cnt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      S_GAP: begin
        state_s = S_IDLE;
        cnt_s   = '0;
        grant_s = '0;
        gfunc_s = 3'd0;
      end
      default: begin
        state_s = S_IDLE;
        cnt_s   = '0;
        grant_s = '0;
        gfunc_s = 3'd0;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r    <= S_IDLE;
      cnt_r      <= '0;
      idx_r      <= '0;
      rr_start_r <= '0;
      lock_r     <= '0;
      Grant      <= '0;
      GrantFunc  <= 3'd0;
      Matriz     <= 7'd0;
      Denied     <= '0;
      Busy       <= 1'b0;
      Timeout    <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      idx_r      <= idx_s;
      rr_start_r <= rr_start_s;
      lock_r     <= lock_s;
      Grant      <= grant_s;
      GrantFunc  <= gfunc_s;
      Matriz     <= (gfunc_s != 3'd0) ? (7'd1 << (gfunc_s - 3'd1)) : 7'd0;
      Denied     <= deny_s;
      Busy       <= (state_s != S_IDLE);
      Timeout    <= timeout_s;
    end
  end

endmodule

// File: tb/tb_arbitro_de_funcionalidade.sv
// Directed bench for arbitro_de_funcionalidade (N_USERS=4, HOLD_CYCLES=8).
module tb_arbitro_de_funcionalidade;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [3:0]  Req;
  logic [11:0] User;
  logic [11:0] Func;
  logic [3:0]  Grant;
  logic [2:0]  GrantFunc;
  logic [6:0]  Matriz;
  logic [3:0]  Denied;
  logic        Busy;
  logic        Timeout;

  int checks   = 0;
  int failures = 0;

  arbitro_de_funcionalidade #(.N_USERS(4), .HOLD_CYCLES(8)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Req       (Req),
    .User      (User),
    .Func      (Func),
    .Grant     (Grant),
    .GrantFunc (GrantFunc),
    .Matriz    (Matriz),
    .Denied    (Denied),
    .Busy      (Busy),
    .Timeout   (Timeout)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic set_ch(input int i, input logic r, input logic [2:0] u, input logic [2:0] f);
    Req[i]        = r;
    User[3*i +: 3] = u;
    Func[3*i +: 3] = f;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input logic [3:0] g, input logic b, input logic t);
    chk({tag, ".grant"},   32'(Grant),   32'(g));
    chk({tag, ".busy"},    32'(Busy),    32'(b));
    chk({tag, ".timeout"}, 32'(Timeout), 32'(t));
  endtask

  task automatic chk_fn(input string tag, input logic [2:0] gf, input logic [6:0] m);
    chk({tag, ".gfunc"},  32'(GrantFunc), 32'(gf));
    chk({tag, ".matriz"}, 32'(Matriz),    32'(m));
  endtask

  initial begin
    // Reset held two cycles with random requests
    Reset = 1'b1;
    Req   = 4'($urandom);
    User  = 12'd0;
    Func  = 12'd0;
    tick();
    Req = 4'($urandom);
    tick();
    chk_st("rst", 4'b0000, 1'b0, 1'b0);
    chk_fn("rst", 3'd0, 7'd0);
    chk("rst.denied", 32'(Denied), 32'(4'b0000));

    // First request after release, granted one edge later
    Reset = 1'b0;
    Req   = 4'b0000;
    set_ch(0, 1'b1, 3'd5, 3'd1);
    tick();
    chk_st("first", 4'b0001, 1'b1, 1'b0);
    set_ch(0, 1'b0, 3'd0, 3'd0);
    tick();
    chk_st("first_gap", 4'b0000, 1'b1, 1'b0);
    tick();
    chk_st("first_idle", 4'b0000, 1'b0, 1'b0);

    // Level priority: ch0 (5) beats ch1 (1)
    set_ch(0, 1'b1, 3'd5, 3'd1);
    set_ch(1, 1'b1, 3'd1, 3'd1);
    tick();
    chk_st("prio", 4'b0001, 1'b1, 1'b0);
    chk_fn("prio", 3'd1, 7'b0000001);
    Req[0] = 1'b0;
    tick();
    chk_st("prio_gap", 4'b0000, 1'b1, 1'b0);
    chk_fn("prio_gap", 3'd0, 7'd0);
    tick();
    chk_st("prio_idle", 4'b0000, 1'b0, 1'b0);
    tick();
    chk_st("prio_ch1", 4'b0010, 1'b1, 1'b0);
    set_ch(1, 1'b0, 3'd0, 3'd0);
    tick();
    tick();

    // Round-robin among equal levels; pointer now starts at 2
    set_ch(0, 1'b1, 3'd3, 3'd2);
    set_ch(1, 1'b1, 3'd3, 3'd2);
    tick();
    chk_st("rr_a", 4'b0001, 1'b1, 1'b0);
    chk_fn("rr_a", 3'd2, 7'b0000010);
    Req[0] = 1'b0;
    tick();
    Req[0] = 1'b1;
    tick();
    tick();
    chk_st("rr_b", 4'b0010, 1'b1, 1'b0);
    Req[1] = 1'b0;
    tick();
    Req[1] = 1'b1;
    tick();
    tick();
    chk_st("rr_c", 4'b0001, 1'b1, 1'b0);
    Req = 4'b0000;
    tick();
    tick();

    // Permission failures
    set_ch(2, 1'b1, 3'd1, 3'd6);
    tick();
    chk("deny_lvl.denied", 32'(Denied), 32'(4'b0100));
    chk_st("deny_lvl", 4'b0000, 1'b0, 1'b0);
    set_ch(2, 1'b0, 3'd0, 3'd0);
    tick();
    chk("deny_clr.denied", 32'(Denied), 32'(4'b0000));
    set_ch(3, 1'b1, 3'd0, 3'd1);
    tick();
    chk("deny_nouser.denied", 32'(Denied), 32'(4'b1000));
    Req = 4'b0000;
    tick();

    // Hold limit, timeout pulse and lockout
    set_ch(3, 1'b1, 3'd7, 3'd4);
    set_ch(1, 1'b1, 3'd2, 3'd1);
    tick();
    chk_st("hold0", 4'b1000, 1'b1, 1'b0);
    chk_fn("hold0", 3'd4, 7'b0001000);
    for (int k = 1; k < 8; k++) begin
      tick();
      chk_st("hold", 4'b1000, 1'b1, 1'b0);
    end
    tick();
    chk_st("tmo", 4'b0000, 1'b1, 1'b1);
    tick();
    chk_st("tmo_idle", 4'b0000, 1'b0, 1'b0);
    tick();
    chk_st("tmo_ch1", 4'b0010, 1'b1, 1'b0);
    Req[1] = 1'b0;
    tick();
    tick();
    tick();
    chk_st("locked", 4'b0000, 1'b0, 1'b0);
    Req[3] = 1'b0;
    tick();
    Req[3] = 1'b1;
    tick();
    chk_st("unlocked", 4'b1000, 1'b1, 1'b0);

    // Reset mid-ACTIVE at cycle 3
    tick();
    tick();
    tick();
    Reset = 1'b1;
    tick();
    chk_st("rst_act", 4'b0000, 1'b0, 1'b0);
    chk_fn("rst_act", 3'd0, 7'd0);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("rst_hold.timeout", 32'(Timeout), 32'(1'b0));
    end
    Reset = 1'b0;
    Req   = 4'b0000;
    tick();
    chk_st("rst_rel", 4'b0000, 1'b0, 1'b0);

    // Drop coinciding with the hold limit: release wins, no lockout
    set_ch(0, 1'b1, 3'd1, 3'd1);
    tick();
    chk_st("coin0", 4'b0001, 1'b1, 1'b0);
    for (int k = 1; k < 8; k++) begin
      tick();
    end
    chk_st("coin7", 4'b0001, 1'b1, 1'b0);
    Req[0] = 1'b0;
    tick();
    chk_st("coin_gap", 4'b0000, 1'b1, 1'b0);
    Req[0] = 1'b1;
    tick();
    tick();
    chk_st("coin_regrant", 4'b0001, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
